mem_port_arbiter: RTL and testbench

- Shares the single external memory port between instruction fetch (IF) and load/store (LS) requesters of the multi-cycle CPU.
- The control unit's FETCH stage drives the IF requester. Its MEMORY_ACCESS stage drives the LS requester.
- The arbiter sequences one transfer at a time, handles memory wait states and returns completion to the requester.
- Its completion signal feeds the control unit's instruction_complete path.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the memory port arbiter.
// slave  : the arbiter's view (drives acks, read data, memory request, status).
// master : the environment's view (requesters and the memory device).
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ack;
    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic [DATA_WIDTH-1:0] ls_rdata;
    logic                  ls_ack;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;
    logic                  bus_error;
    logic                  busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, ls_rdata, ls_ack, mem_req, mem_we, mem_addr, mem_wdata,
               bus_error, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, ls_rdata, ls_ack, mem_req, mem_we, mem_addr, mem_wdata,
               bus_error, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and
// load/store (LS). One transfer at a time, LS priority with IF starvation guard,
// all outputs registered.
// Optional macro BUS_TIMEOUT_EN: abort a transfer after TIMEOUT_CYCLES cycles
// without mem_ready and flag it with bus_error.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic               clock,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER_IF = 2'd1,
        XFER_LS = 2'd2
    } state_t;

    localparam int              SCW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0]  STARVE_MAX = SCW'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic [SCW-1:0]        starve_cnt_q, starve_cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  if_ack_q, if_ack_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
    logic                  ls_ack_q, ls_ack_d;
    logic                  busy_q, busy_d;
    logic                  abort;

`ifdef BUS_TIMEOUT_EN
    localparam int             TCW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic           bus_error_q, bus_error_d;

    // Timeout counter and error flag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Abort on the last allowed wait cycle; mem_ready on that same cycle wins
    always_comb begin
        abort       = !bus.mem_ready && (tmo_cnt_q == TMO_LAST);
        tmo_cnt_d   = tmo_cnt_q;
        bus_error_d = 1'b0;
        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if (abort) begin
            tmo_cnt_d   = '0;
            bus_error_d = 1'b1;
        end else if (!bus.mem_ready) begin
            tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
    end

    assign bus.bus_error = bus_error_q;
`else
    assign abort         = 1'b0;
    assign bus.bus_error = 1'b0;
`endif

    // State and registered-output flops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            ls_rdata_q   <= '0;
            ls_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            if_ack_q     <= if_ack_d;
            ls_rdata_q   <= ls_rdata_d;
            ls_ack_q     <= ls_ack_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, grant arbitration and completion handling
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        if_ack_d     = 1'b0;
        ls_rdata_d   = ls_rdata_q;
        ls_ack_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!bus.if_req) begin
                    starve_cnt_d = '0;
                end
                // The cycle an ack is visible grants nothing: the acked requester
                // is still dropping its level request, and holding the other one
                // back keeps LS priority (and hence the starvation count) meaningful.
                if (!(if_ack_q || ls_ack_q)) begin
                    if (bus.if_req && (starve_cnt_q == STARVE_MAX || !bus.ls_req)) begin
                        state_d      = XFER_IF;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = bus.if_addr;
                        mem_wdata_d  = '0;
                        starve_cnt_d = '0;
                    end else if (bus.ls_req) begin
                        state_d     = XFER_LS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.ls_we;
                        mem_addr_d  = bus.ls_addr;
                        mem_wdata_d = bus.ls_wdata;
                        if (bus.if_req && starve_cnt_q != STARVE_MAX) begin
                            starve_cnt_d = starve_cnt_q + SCW'(1);
                        end
                    end
                end
            end
            XFER_IF: begin
                if (bus.mem_ready || abort) begin
                    if_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                    if_ack_d   = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            XFER_LS: begin
                if (bus.mem_ready) begin
                    if (!mem_we_q) begin
                        ls_rdata_d = bus.mem_rdata;
                    end
                    ls_ack_d  = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (abort) begin
                    ls_rdata_d = '0;
                    ls_ack_d   = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_ack    = ls_ack_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed-vector bench for mem_port_arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (16),
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
    endtask

    // Both acks must never be high together
    always @(negedge clock) begin
        if (reset_n) check("ack_exclusive", 32'(bus.if_ack & bus.ls_ack), 32'd0);
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle_inputs();

        // Reset held with random inputs
        for (int unsigned i = 0; i < 3; i++) begin
            bus.if_req    = 1'($urandom);
            bus.if_addr   = 16'($urandom);
            bus.ls_req    = 1'($urandom);
            bus.ls_we     = 1'($urandom);
            bus.ls_addr   = 16'($urandom);
            bus.ls_wdata  = 16'($urandom);
            bus.mem_rdata = 16'($urandom);
            bus.mem_ready = 1'($urandom);
            tick();
        end
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_if_ack", 32'(bus.if_ack), 32'd0);
        check("rst_ls_ack", 32'(bus.ls_ack), 32'd0);
        check("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
        check("rst_ls_rdata", 32'(bus.ls_rdata), 32'd0);
        check("rst_bus_error", 32'(bus.bus_error), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        idle_inputs();
        reset_n = 1'b1;
        tick();

        // mem_ready in IDLE is ignored
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        tick();
        check("idle_rdy_busy", 32'(bus.busy), 32'd0);
        check("idle_rdy_ack", 32'({bus.if_ack, bus.ls_ack}), 32'd0);
        bus.mem_ready = 1'b0;

        // Zero-wait fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0040;
        tick();
        check("fetch_mem_req", 32'(bus.mem_req), 32'd1);
        check("fetch_mem_addr", 32'(bus.mem_addr), 32'h0040);
        check("fetch_mem_we", 32'(bus.mem_we), 32'd0);
        check("fetch_busy", 32'(bus.busy), 32'd1);
        check("fetch_no_ack_yet", 32'(bus.if_ack), 32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        tick();
        check("fetch_ack", 32'(bus.if_ack), 32'd1);
        check("fetch_rdata", 32'(bus.if_rdata), 32'hBEEF);
        check("fetch_mem_req_drop", 32'(bus.mem_req), 32'd0);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("fetch_ack_pulse", 32'(bus.if_ack), 32'd0);
        check("fetch_idle", 32'(bus.busy), 32'd0);

        // Store with 3 wait states
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 16'h1234;
        bus.ls_wdata = 16'h00AA;
        tick();
        check("store_mem_addr", 32'(bus.mem_addr), 32'h1234);
        for (int unsigned i = 0; i < 4; i++) begin
            if (i != 0) tick();
            check("store_mem_we", 32'(bus.mem_we), 32'd1);
            check("store_mem_wdata", 32'(bus.mem_wdata), 32'h00AA);
            check("store_mem_req", 32'(bus.mem_req), 32'd1);
            check("store_no_ack", 32'(bus.ls_ack), 32'd0);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h5555;
        tick();
        check("store_ack", 32'(bus.ls_ack), 32'd1);
        check("store_rdata_kept", 32'(bus.ls_rdata), 32'h0000);
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Contention: LS first, then IF
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0100;
        bus.ls_req  = 1'b1;
        bus.ls_addr = 16'h0200;
        tick();
        check("cont_ls_first", 32'(bus.mem_addr), 32'h0200);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h1111;
        tick();
        check("cont_ls_ack", 32'(bus.ls_ack), 32'd1);
        check("cont_ls_rdata", 32'(bus.ls_rdata), 32'h1111);
        bus.ls_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("cont_gap", 32'(bus.mem_req), 32'd0);
        tick();
        check("cont_if_second", 32'(bus.mem_addr), 32'h0100);
        check("cont_if_req", 32'(bus.mem_req), 32'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h2222;
        tick();
        check("cont_if_ack", 32'(bus.if_ack), 32'd1);
        check("cont_if_rdata", 32'(bus.if_rdata), 32'h2222);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Starvation: IF held, LS re-requested after every ack
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0300;
        for (int unsigned k = 0; k < 4; k++) begin
            bus.ls_req  = 1'b1;
            bus.ls_addr = 16'h0400 + 16'(k);
            tick();
            check("starve_ls_grant", 32'(bus.mem_addr), 32'h0400 + k);
            check("starve_count", 32'(dut.starve_cnt_q), k + 1);
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 16'h7000 + 16'(k);
            tick();
            check("starve_ls_ack", 32'(bus.ls_ack), 32'd1);
            bus.ls_req    = 1'b0;
            bus.mem_ready = 1'b0;
            tick();
        end
        bus.ls_req  = 1'b1;
        bus.ls_addr = 16'h0404;
        tick();
        check("starve_if_forced", 32'(bus.mem_addr), 32'h0300);
        check("starve_count_clr", 32'(dut.starve_cnt_q), 32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h3333;
        tick();
        check("starve_if_ack", 32'(bus.if_ack), 32'd1);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        check("starve_ls_after", 32'(bus.mem_addr), 32'h0404);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h7777;
        tick();
        check("starve_ls_last_ack", 32'(bus.ls_ack), 32'd1);
        check("starve_ls_rdata", 32'(bus.ls_rdata), 32'h7777);
        bus.ls_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Reset during XFER_LS abandons the transfer
        bus.ls_req  = 1'b1;
        bus.ls_addr = 16'h0600;
        tick();
        check("mid_rst_busy_before", 32'(bus.busy), 32'd1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ls_ack", 32'(bus.ls_ack), 32'd0);
        bus.ls_req    = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        check("mid_rst_no_ack", 32'(bus.ls_ack), 32'd0);
        bus.mem_ready = 1'b0;
        reset_n       = 1'b1;
        tick();

        // Prime ls_rdata with a nonzero load result
        bus.ls_req  = 1'b1;
        bus.ls_addr = 16'h0700;
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hA5A5;
        tick();
        check("prime_ls_rdata", 32'(bus.ls_rdata), 32'hA5A5);
        bus.ls_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

`ifdef BUS_TIMEOUT_EN
        // Load never answered: aborted on the 15th wait cycle
        bus.ls_req  = 1'b1;
        bus.ls_addr = 16'h0500;
        tick();
        for (int unsigned i = 0; i < 14; i++) tick();
        check("tmo_not_yet", 32'(bus.ls_ack), 32'd0);
        check("tmo_busy_wait", 32'(bus.busy), 32'd1);
        tick();
        check("tmo_ls_ack", 32'(bus.ls_ack), 32'd1);
        check("tmo_bus_error", 32'(bus.bus_error), 32'd1);
        check("tmo_ls_rdata", 32'(bus.ls_rdata), 32'h0000);
        check("tmo_mem_req", 32'(bus.mem_req), 32'd0);
        bus.ls_req = 1'b0;
        tick();
        check("tmo_err_pulse", 32'(bus.bus_error), 32'd0);
        check("tmo_idle", 32'(bus.busy), 32'd0);

        // mem_ready on the timeout cycle completes normally
        bus.ls_req  = 1'b1;
        bus.ls_addr = 16'h0502;
        tick();
        for (int unsigned i = 0; i < 14; i++) tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h9999;
        tick();
        check("tmo_race_ack", 32'(bus.ls_ack), 32'd1);
        check("tmo_race_no_err", 32'(bus.bus_error), 32'd0);
        check("tmo_race_rdata", 32'(bus.ls_rdata), 32'h9999);
        bus.ls_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
`else
        // Without the timeout the transfer waits indefinitely
        bus.ls_req  = 1'b1;
        bus.ls_addr = 16'h0500;
        tick();
        for (int unsigned i = 0; i < 50; i++) tick();
        check("notmo_busy", 32'(bus.busy), 32'd1);
        check("notmo_no_ack", 32'(bus.ls_ack), 32'd0);
        check("notmo_bus_error", 32'(bus.bus_error), 32'd0);
        reset_n    = 1'b0;
        bus.ls_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
